// File: rtl/seq_normalize.sv
// Iterative left-normalizer: shifts a 16-bit operand left one bit per clock until normalized,
// reporting the shift count. Define NORM_FAST2_EN to allow two-bit steps when both are safe.
module seq_normalize #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_CAP     = 5'd15;
    localparam logic [CNT_W-1:0] CNT_DEG_U   = 5'd16;
    localparam logic [CNT_W-1:0] CNT_DEG_S   = 5'd15;
    localparam logic [WIDTH-1:0] WORD_ZERO   = 16'h0000;
    localparam logic [WIDTH-1:0] WORD_ONES   = 16'hFFFF;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             zero_q, zero_d;
    logic             norm_s;
    logic             stop_s;

    function automatic logic is_normalized(input logic [WIDTH-1:0] r, input logic m);
        logic res;
        if (m) begin
            res = (r[WIDTH-1] != r[WIDTH-2]);
        end else begin
            res = r[WIDTH-1];
        end
        return res;
    endfunction

    function automatic logic is_degenerate(input logic [WIDTH-1:0] r, input logic m);
        logic res;
        if (m) begin
            res = (r == WORD_ZERO) || (r == WORD_ONES);
        end else begin
            res = (r == WORD_ZERO);
        end
        return res;
    endfunction

`ifdef NORM_FAST2_EN
    // A double step is safe only when the intermediate single shift would not normalize.
    function automatic logic can_double(input logic [WIDTH-1:0] r, input logic m);
        logic res;
        if (m) begin
            res = (r[WIDTH-1] == r[WIDTH-2]) && (r[WIDTH-2] == r[WIDTH-3]);
        end else begin
            res = (r[WIDTH-1:WIDTH-2] == 2'b00);
        end
        return res;
    endfunction
`endif

    assign norm_s = is_normalized(reg_q, mode_q);
    assign stop_s = zero_q || norm_s || (count_q == CNT_CAP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: load on accepted start, shift while running, otherwise hold.
    always_comb begin
        reg_d   = reg_q;
        count_d = count_q;
        mode_d  = mode_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reg_d   = in;
                    mode_d  = mode;
                    count_d = 5'd0;
                    zero_d  = is_degenerate(in, mode);
                end else begin
                    reg_d = reg_q;
                end
            end
            ST_RUN: begin
                if (zero_q) begin
                    // Degenerate operands report the full-width count without shifting.
                    if (mode_q) begin
                        count_d = CNT_DEG_S;
                    end else begin
                        count_d = CNT_DEG_U;
                    end
                end else if (norm_s || (count_q == CNT_CAP)) begin
                    count_d = count_q;
                end else begin
`ifdef NORM_FAST2_EN
                    if (can_double(reg_q, mode_q) && (count_q <= 5'd13)) begin
                        reg_d   = {reg_q[WIDTH-3:0], 2'b00};
                        count_d = count_q + 5'd2;
                    end else begin
                        reg_d   = {reg_q[WIDTH-2:0], 1'b0};
                        count_d = count_q + 5'd1;
                    end
`else
                    reg_d   = {reg_q[WIDTH-2:0], 1'b0};
                    count_d = count_q + 5'd1;
`endif
                end
            end
            ST_DONE: begin
                reg_d = reg_q;
            end
            default: begin
                reg_d = reg_q;
            end
        endcase
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q   <= 16'h0000;
            count_q <= 5'd0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            reg_q   <= reg_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            zero_q  <= zero_d;
        end
    end

    // Output decode from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign out   = reg_q;
    assign count = count_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_seq_normalize.sv
// Self-checking bench for seq_normalize: directed plan cases plus randomized operands
// compared against a leading-bit reference model.
module tb_seq_normalize;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic [4:0]  count;
    logic        zero;

    int errors = 0;
    int checks = 0;

    seq_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .in    (din),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .count (count),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: shift count is the distance from the top to the most significant
    // bit that differs from the fill (unsigned: first 1; signed: first bit != sign).
    function automatic void model(input logic m, input logic [15:0] v,
                                  output logic [15:0] eo, output int ec,
                                  output logic ez, output int elat);
        int k;
        k = -1;
        for (int i = 15; i >= 0; i--) begin
            if (k < 0) begin
                if (!m && v[i]) k = i;
                if (m && i < 15 && v[i] != v[15]) k = i;
            end
        end
        if (k < 0) begin
            eo   = v;
            ec   = m ? 15 : 16;
            ez   = 1'b1;
            elat = 2;
        end else begin
            ec   = m ? (14 - k) : (15 - k);
            eo   = 16'(v << ec);
            ez   = 1'b0;
`ifdef NORM_FAST2_EN
            elat = 2 + (ec + 1) / 2;
`else
            elat = 2 + ec;
`endif
        end
    endfunction

    // Called at a negedge; issues start there and returns at the IDLE negedge after done.
    task automatic run_op(input logic m, input logic [15:0] v, input bit spam, input string tag);
        logic [15:0] eo;
        int          ec;
        logic        ez;
        int          elat;
        int          lat;
        bit          got;
        model(m, v, eo, ec, ez, elat);
        start = 1'b1;
        mode  = m;
        din   = v;
        lat   = 0;
        got   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                lat   = c;
                got   = 1'b1;
                break;
            end
            check_eq({tag, " busy_run"}, 32'(busy), 32'd1);
            if (spam) begin
                start = 1'b1;
                din   = 16'($urandom);
                mode  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        if (!got) begin
            check_eq({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, " latency"}, 32'(lat), 32'(elat));
            check_eq({tag, " out"}, 32'(out), 32'(eo));
            check_eq({tag, " count"}, 32'(count), 32'(ec));
            check_eq({tag, " zero"}, 32'(zero), 32'(ez));
            check_eq({tag, " busy_done"}, 32'(busy), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, " done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, " busy_idle"}, 32'(busy), 32'd0);
        check_eq({tag, " out_held"}, 32'(out), 32'(eo));
        check_eq({tag, " count_held"}, 32'(count), 32'(ec));
    endtask

    initial begin
        logic [15:0] rv;
        logic        rm;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        din   = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("rst out", 32'(out), 32'd0);
        check_eq("rst count", 32'(count), 32'd0);
        check_eq("rst zero", 32'(zero), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'h0001, 1'b0, "u0001");
        run_op(1'b0, 16'h8000, 1'b0, "u8000");
        run_op(1'b1, 16'h4000, 1'b0, "s4000_b2b");
        run_op(1'b1, 16'hFFF0, 1'b0, "sFFF0");
        run_op(1'b1, 16'h0003, 1'b0, "s0003");
        run_op(1'b0, 16'h0000, 1'b0, "u0000");
        run_op(1'b1, 16'hFFFF, 1'b0, "sFFFF");
        run_op(1'b1, 16'h0000, 1'b0, "s0000");
        run_op(1'b0, 16'h0001, 1'b1, "spam");

        // Asynchronous reset between edges in the middle of a long run.
        start = 1'b1;
        mode  = 1'b0;
        din   = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre_rst busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst out", 32'(out), 32'd0);
        check_eq("async_rst count", 32'(count), 32'd0);
        check_eq("async_rst zero", 32'(zero), 32'd0);
        check_eq("async_rst busy", 32'(busy), 32'd0);
        check_eq("async_rst done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 16'h00F0, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            rm = 1'($urandom);
            rv = 16'($urandom) >> $urandom_range(0, 15);
            if (rm && $urandom_range(0, 1) == 1) rv = ~rv;
            run_op(rm, rv, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
